// File: rtl/sram_async_ctrl_if.sv
// Request/response bus between the system bus decoder and the async SRAM bridge.
interface sram_async_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  busy;

  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_async_ctrl.sv
// Clocked bridge to an asynchronous SRAM with parametrised setup/strobe/hold phases.
// Optional feature macro: SRAM_CTRL_POSTED_WRITE_EN (write ack one cycle after acceptance).
module sram_async_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 15,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_async_ctrl_if.slave      bus,
  output logic                  sram_ncs,
  output logic                  sram_nwe,
  output logic                  sram_noe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  localparam int unsigned MAX_ST    = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned MAX_PHASE = (MAX_ST > HOLD_CYCLES) ? MAX_ST : HOLD_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_PHASE + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef SRAM_CTRL_POSTED_WRITE_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                state;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_d;
  logic                  accept;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  data_oe;

  logic we_n;
  logic ncs_d;
  logic nwe_d;
  logic noe_d;
  logic oe_d;
  logic busy_d;
  logic ack_d;
  logic capture;

  // State, phase counter and every registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      sram_addr <= '0;
      sram_ncs  <= 1'b1;
      sram_nwe  <= 1'b1;
      sram_noe  <= 1'b1;
      data_oe   <= 1'b0;
      bus.rdata <= '0;
      bus.ack   <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      sram_ncs <= ncs_d;
      sram_nwe <= nwe_d;
      sram_noe <= noe_d;
      data_oe  <= oe_d;
      bus.ack  <= ack_d;
      bus.busy <= busy_d;
      if (accept) begin
        we_q      <= bus.we;
        sram_addr <= bus.addr;
        wdata_q   <= bus.wdata;
      end
      if (capture) begin
        bus.rdata <= sram_data;
      end
    end
  end

  // Phase sequencing; the counter reloads on every phase entry and counts down to zero
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
          accept  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == CNT_ZERO) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt == CNT_ZERO) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt == CNT_ZERO) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Next values of the registered pins, derived from the next state so strobes never glitch
  always_comb begin
    we_n    = accept ? bus.we : we_q;
    ncs_d   = (state_d == IDLE);
    nwe_d   = !((state_d == STROBE) && we_n);
    noe_d   = !((state_d == STROBE) && !we_n);
    oe_d    = (state_d != IDLE) && we_n;
    busy_d  = (state_d != IDLE);
    capture = (state == STROBE) && (state_d != STROBE) && !we_q;
    ack_d   = ((state == HOLD) && (state_d == IDLE) && !(POSTED && we_q)) ||
              (POSTED && we_q && (state == SETUP) && (cnt == SETUP_LOAD));
  end

  assign sram_data = data_oe ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
